// File: rtl/icache_direct_ctrl_if.sv
// icache_direct_ctrl_if: fetch-side request/response and backing-memory signals of the instruction cache
interface icache_direct_ctrl_if;
  logic [15:0] Addr;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_valid;
  modport slave (
    input  Addr, Rd, Wr, mem_data, mem_valid,
    output DataOut, Done, Stall, CacheHit, err, mem_addr, mem_rd
  );
  modport master (
    output Addr, Rd, Wr, mem_data, mem_valid,
    input  DataOut, Done, Stall, CacheHit, err, mem_addr, mem_rd
  );
endinterface

// File: rtl/icache_direct_ctrl.sv
// icache_direct_ctrl: read-only direct-mapped instruction cache, 4-word lines filled from a pipelined word memory
module icache_direct_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input logic                 clk,
  input logic                 rst,
  icache_direct_ctrl_if.slave bus
);
  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 13 - INDEX_BITS;
  localparam logic [1:0] IDLE = 2'd0, FILL_REQ = 2'd1, FILL_WAIT = 2'd2, RESPOND = 2'd3;
  logic [1:0]            state;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags [LINES];
  logic [15:0]           lines [LINES][4];
  logic [15:0]           fill_buf [4];
  logic [15:0]           resp_word;
  logic [15:1]           req_addr;
  logic [1:0]            iss_cnt, rx_cnt;
  logic [INDEX_BITS-1:0] idx, req_idx;
  logic [TAG_W-1:0]      tag, req_tag;
  logic [1:0]            off, req_off;
  logic                  idle, illegal, req_ok, hit, filling, cap, last;
  assign idx     = bus.Addr[2+INDEX_BITS:3];
  assign tag     = bus.Addr[15:3+INDEX_BITS];
  assign off     = bus.Addr[2:1];
  assign req_idx = req_addr[2+INDEX_BITS:3];
  assign req_tag = req_addr[15:3+INDEX_BITS];
  assign req_off = req_addr[2:1];
  assign idle    = state == IDLE;
  assign illegal = bus.Wr || (bus.Rd && bus.Addr[0]);
  assign req_ok  = bus.Rd && !illegal;
  assign hit     = valid[idx] && tags[idx] == tag;
  assign filling = state == FILL_REQ || state == FILL_WAIT;
  assign cap     = filling && bus.mem_valid;
  assign last    = cap && rx_cnt == 2'd3;
  // fetch-side responses are combinational so hits and errors complete in the request cycle
  always_comb begin
    bus.err      = idle && illegal;
    bus.CacheHit = idle && req_ok && hit;
    bus.Done     = bus.CacheHit || state == RESPOND;
    bus.Stall    = (idle && req_ok && !hit) || filling;
    bus.DataOut  = bus.CacheHit ? lines[idx][off] : state == RESPOND ? resp_word : 16'h0;
    bus.mem_rd   = state == FILL_REQ;
    bus.mem_addr = bus.mem_rd ? {req_addr[15:3], iss_cnt, 1'b0} : 16'h0;
  end
  // control: miss capture, issue/receive counters, line validation; reset aborts any fill in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      iss_cnt  <= '0;
      rx_cnt   <= '0;
      req_addr <= '0;
    end else begin
      if (idle && req_ok && !hit) begin
        req_addr <= bus.Addr[15:1];
        iss_cnt  <= '0;
        rx_cnt   <= '0;
        state    <= FILL_REQ;
      end
      if (bus.mem_rd) iss_cnt <= iss_cnt + 2'd1;
      if (cap) rx_cnt <= rx_cnt + 2'd1;
      if (state == FILL_REQ && iss_cnt == 2'd3) state <= FILL_WAIT;
      if (last) begin
        valid[req_idx] <= 1'b1;
        state          <= RESPOND;
      end
      if (state == RESPOND) state <= IDLE;
    end
  end
  // datapath: collect fill words and install the whole line with the final word; only valid bits need reset
  always_ff @(posedge clk) begin
    if (cap) fill_buf[rx_cnt] <= bus.mem_data;
    if (last) begin
      tags[req_idx]     <= req_tag;
      lines[req_idx][0] <= fill_buf[0];
      lines[req_idx][1] <= fill_buf[1];
      lines[req_idx][2] <= fill_buf[2];
      lines[req_idx][3] <= bus.mem_data;
      resp_word         <= req_off == 2'd3 ? bus.mem_data : fill_buf[req_off];
    end
  end
endmodule
